reg_xfer_ctrl: RTL and testbench

Bus-side controller for the register file built from RegAC-style registers (WR / LDBUS / LDALU strobes, 16-bit BIN/BOUT).
- Accepts one transfer request at a time.
- Sequences the per-register control strobes: source drives the bus, destination writes from the bus, AC loads from the ALU.
- Muxes the selected register output onto the shared bus.
- Sits between the instruction decoder and the register bank.

---
 rtl/reg_xfer_pkg.sv | 23 ++
 rtl/reg_xfer_ctrl_if.sv | 28 ++
 rtl/reg_bus_mux.sv | 21 ++
 rtl/reg_xfer_ctrl.sv | 83 ++++++++
 tb/tb_reg_xfer_ctrl.sv | 169 ++++++++++++++++
 5 files changed

// File: rtl/reg_xfer_pkg.sv
// reg_xfer_pkg: shared encodings and default sizes for the register transfer controller
package reg_xfer_pkg;

    localparam int DEF_NREG  = 8;
    localparam int DEF_WIDTH = 16;
    localparam int DEF_SELW  = 3;

    typedef enum logic [1:0] {
        OP_MOVE  = 2'b00,
        OP_IMM   = 2'b01,
        OP_ALULD = 2'b10,
        OP_RSVD  = 2'b11
    } op_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRIVE,
        S_WRITE,
        S_DONE,
        S_ERR
    } state_t;

endpackage

// File: rtl/reg_xfer_ctrl_if.sv
// reg_xfer_ctrl_if: decoder-to-controller request/response channel
interface reg_xfer_ctrl_if
    import reg_xfer_pkg::*;
#(
    parameter int SELW  = DEF_SELW,
    parameter int WIDTH = DEF_WIDTH
);

    logic             req_valid;
    logic             req_ready;
    op_t              req_op;
    logic [SELW-1:0]  req_src;
    logic [SELW-1:0]  req_dst;
    logic [WIDTH-1:0] req_imm;
    logic             done;
    logic             err;

    modport master (
        output req_valid, req_op, req_src, req_dst, req_imm,
        input  req_ready, done, err
    );

    modport slave (
        input  req_valid, req_op, req_src, req_dst, req_imm,
        output req_ready, done, err
    );

endinterface

// File: rtl/reg_bus_mux.sv
// reg_bus_mux: NREG:1 register output mux onto the shared bus, zero when disabled
module reg_bus_mux
    import reg_xfer_pkg::*;
#(
    parameter int NREG  = DEF_NREG,
    parameter int WIDTH = DEF_WIDTH,
    parameter int SELW  = DEF_SELW
) (
    input  logic [SELW-1:0]       sel,
    input  logic                  en,
    input  logic [NREG*WIDTH-1:0] din,
    output logic [WIDTH-1:0]      dout
);

    always_comb begin
        dout = '0;
        for (int i = 0; i < NREG; i++)
            if (en && sel == SELW'(i)) dout = din[i*WIDTH +: WIDTH];
    end

endmodule

// File: rtl/reg_xfer_ctrl.sv
// reg_xfer_ctrl: sequences LDBUS/WR/LDALU strobes for one register transfer at a time
module reg_xfer_ctrl
    import reg_xfer_pkg::*;
#(
    parameter int NREG   = DEF_NREG,
    parameter int WIDTH  = DEF_WIDTH,
    parameter int SELW   = DEF_SELW,
    parameter int AC_IDX = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    reg_xfer_ctrl_if.slave        bus,
    input  logic [NREG*WIDTH-1:0] reg_bout,
    output logic [NREG-1:0]       ld_bus,
    output logic [NREG-1:0]       wr,
    output logic                  ld_alu,
    output logic [WIDTH-1:0]      bus_data
);

    state_t           state, state_n;
    op_t              op_q;
    logic [SELW-1:0]  src_q, dst_q;
    logic [WIDTH-1:0] imm_q, mux_out;
    logic             bad, busy, src_drv;

    assign bad = bus.req_op == OP_RSVD
              || (bus.req_op == OP_MOVE && int'(bus.req_src) >= NREG)
              || (bus.req_op != OP_ALULD && int'(bus.req_dst) >= NREG);

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state <= S_IDLE;
            op_q  <= OP_MOVE;
            src_q <= '0;
            dst_q <= '0;
            imm_q <= '0;
        end else begin
            state <= state_n;
            if (bus.req_valid && bus.req_ready) begin
                op_q  <= bus.req_op;
                src_q <= bus.req_src;
                dst_q <= bus.req_dst;
                imm_q <= bus.req_imm;
            end
        end

    // ALU loads have no bus source, so they go straight to the write phase
    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:  if (bus.req_valid) state_n = bad ? S_ERR : (bus.req_op == OP_ALULD ? S_WRITE : S_DRIVE);
            S_DRIVE: state_n = S_WRITE;
            S_WRITE: state_n = S_DONE;
            default: state_n = S_IDLE;
        endcase
    end

    assign busy    = state == S_DRIVE || state == S_WRITE;
    assign src_drv = busy && op_q == OP_MOVE;

    always_comb begin
        ld_bus = '0;
        wr     = '0;
        for (int i = 0; i < NREG; i++) begin
            ld_bus[i] = src_drv && src_q == SELW'(i);
            wr[i]     = state == S_WRITE && (op_q == OP_MOVE || op_q == OP_IMM) && dst_q == SELW'(i);
        end
    end

    assign ld_alu        = state == S_WRITE && op_q == OP_ALULD && AC_IDX < NREG;
    assign bus_data      = busy && op_q == OP_IMM ? imm_q : mux_out;
    assign bus.req_ready = state == S_IDLE;
    assign bus.done      = state == S_DONE;
    assign bus.err       = state == S_ERR;

    reg_bus_mux #(.NREG(NREG), .WIDTH(WIDTH), .SELW(SELW)) u_mux (
        .sel  (src_q),
        .en   (src_drv),
        .din  (reg_bout),
        .dout (mux_out)
    );

endmodule

// File: tb/tb_reg_xfer_ctrl.sv
// tb_reg_xfer_ctrl: randomized transfers against a transaction-level register file model
module tb_reg_xfer_ctrl;
    import reg_xfer_pkg::*;

    localparam int NREG  = 8;
    localparam int WIDTH = 16;
    localparam int SELW  = 4;
    localparam int AC    = 0;
    localparam int IW    = $clog2(NREG);

    logic                  clk = 0;
    logic                  rst = 1;
    logic [NREG*WIDTH-1:0] reg_bout;
    logic [NREG-1:0]       ld_bus, wr;
    logic                  ld_alu;
    logic [WIDTH-1:0]      bus_data;
    logic [WIDTH-1:0]      regs [NREG];
    logic [WIDTH-1:0]      mregs [NREG];
    logic [WIDTH-1:0]      alu_val = '0;
    int                    errors = 0;
    int                    checks = 0;

    reg_xfer_ctrl_if #(.SELW(SELW), .WIDTH(WIDTH)) bus ();

    reg_xfer_ctrl #(.NREG(NREG), .WIDTH(WIDTH), .SELW(SELW), .AC_IDX(AC)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus.slave),
        .reg_bout (reg_bout),
        .ld_bus   (ld_bus),
        .wr       (wr),
        .ld_alu   (ld_alu),
        .bus_data (bus_data)
    );

    always #5 clk = ~clk;

    // behavioural register bank: RegAC-style WR from bus, LDALU from the ALU
    always_comb
        for (int i = 0; i < NREG; i++) reg_bout[i*WIDTH +: WIDTH] = regs[i];

    always @(posedge clk)
        for (int i = 0; i < NREG; i++)
            if (wr[i]) regs[i] <= bus_data;
            else if (ld_alu && i == AC) regs[i] <= alu_val;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    always @(negedge clk)
        check("invariant", 32'($onehot0(ld_bus) && $onehot0(wr) && !(ld_alu && |wr)), 1);

    task automatic garbage();
        bus.req_valid = 1;
        bus.req_op    = op_t'($urandom_range(0, 3));
        bus.req_src   = SELW'($urandom);
        bus.req_dst   = SELW'($urandom);
        bus.req_imm   = WIDTH'($urandom);
    endtask

    task automatic issue(op_t op, int src, int dst, logic [WIDTH-1:0] imm);
        bit               bad;
        int               n, idx;
        logic [WIDTH-1:0] sv, val;
        logic [NREG-1:0]  e_ld, e_wr;
        bad = op == OP_RSVD || (op == OP_MOVE && src >= NREG) || (op != OP_ALULD && dst >= NREG);
        n   = bad ? 1 : op == OP_ALULD ? 2 : 3;
        sv  = op == OP_MOVE && src < NREG ? mregs[IW'(src)] : imm;
        if (op == OP_ALULD) alu_val = WIDTH'($urandom);
        check("ready_idle", 32'(bus.req_ready), 1);
        bus.req_valid = 1;
        bus.req_op    = op;
        bus.req_src   = SELW'(src);
        bus.req_dst   = SELW'(dst);
        bus.req_imm   = imm;
        @(posedge clk);
        for (int c = 1; c <= n; c++) begin
            @(negedge clk);
            garbage();
            e_ld = !bad && op == OP_MOVE && c <= 2 ? NREG'(1 << src) : '0;
            e_wr = !bad && op != OP_ALULD && c == 2 ? NREG'(1 << dst) : '0;
            check("ld_bus", 32'(ld_bus), 32'(e_ld));
            check("wr", 32'(wr), 32'(e_wr));
            check("ld_alu", 32'(ld_alu), 32'(!bad && op == OP_ALULD && c == 1));
            check("bus_data", 32'(bus_data), 32'(!bad && op != OP_ALULD && c <= 2 ? sv : '0));
            check("done", 32'(bus.done), 32'(!bad && c == n));
            check("err", 32'(bus.err), 32'(bad));
            check("ready_busy", 32'(bus.req_ready), 0);
        end
        if (!bad) begin
            idx = op == OP_ALULD ? AC : dst;
            val = op == OP_ALULD ? alu_val : sv;
            mregs[IW'(idx)] = val;
        end
        @(negedge clk);
        bus.req_valid = 0;
        check("ready_back", 32'(bus.req_ready), 1);
        check("done_idle", 32'(bus.done), 0);
        check("err_idle", 32'(bus.err), 0);
        check("bus_idle", 32'({ld_bus, wr, ld_alu, bus_data}), 0);
        if (!bad) check("reg", 32'(regs[IW'(idx)]), 32'(mregs[IW'(idx)]));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.req_valid = 0;
        bus.req_op    = OP_MOVE;
        bus.req_src   = '0;
        bus.req_dst   = '0;
        bus.req_imm   = '0;
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(bus.req_ready), 1);
        check("rst_strobes", 32'({ld_bus, wr, ld_alu}), 0);
        check("rst_bus", 32'(bus_data), 0);
        check("rst_resp", 32'({bus.done, bus.err}), 0);
        rst = 0;
        issue(OP_IMM, 0, 2, 16'd16);
        for (int i = 0; i < NREG; i++)
            if (i != 2) issue(OP_IMM, 0, i, WIDTH'($urandom));
        issue(OP_IMM, 0, 2, 16'd64);
        issue(OP_MOVE, 2, 5, '0);
        issue(OP_ALULD, 0, 0, '0);
        issue(OP_RSVD, 1, 1, '0);
        issue(OP_MOVE, 7, 9, '0);
        issue(OP_IMM, 0, 8, 16'hbeef);
        issue(OP_MOVE, 8, 1, '0);
        issue(OP_MOVE, 3, 3, '0);
        issue(OP_MOVE, 7, 0, '0);
        // reset lands during the write phase of MOVE 1->3
        bus.req_valid = 1;
        bus.req_op    = OP_MOVE;
        bus.req_src   = 4'd1;
        bus.req_dst   = 4'd3;
        @(posedge clk);
        @(negedge clk);
        garbage();
        check("rst_drive_ld", 32'(ld_bus), 32'h02);
        @(negedge clk);
        check("rst_write_wr", 32'(wr), 32'h08);
        #1 rst = 1;
        #1;
        check("rst_mid_strobes", 32'({ld_bus, wr, ld_alu}), 0);
        check("rst_mid_bus", 32'(bus_data), 0);
        check("rst_mid_ready", 32'(bus.req_ready), 1);
        bus.req_valid = 0;
        @(negedge clk);
        check("rst_no_done", 32'(bus.done), 0);
        check("rst_reg3", 32'(regs[3]), 32'(mregs[3]));
        rst = 0;
        issue(OP_MOVE, 1, 3, '0);
        issue(OP_MOVE, 0, 1, '0);
        issue(OP_IMM, 0, 1, 16'd32);
        for (int k = 0; k < 60; k++)
            issue(op_t'($urandom_range(0, 3)), int'($urandom_range(0, 9)), int'($urandom_range(0, 9)), WIDTH'($urandom));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
